affine_seq: RTL
===============

AFFINE_SEQ -- requirements
Module: affine_seq

Interface
REQ-001 Parameter: n, default 8, datapath width in bits; equals the ALU width.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: nReset  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a transform; sampled only in IDLE.
REQ-005 Port: x_in, y_in  input  n each  signed integer input point.
REQ-006 Port: a11, a12, a21, a22  input  n each  signed Q1.7 coefficients.
REQ-007 Port: b1, b2  input  n each  signed integer offsets.
REQ-008 Port: alu_a, alu_b  output  n each  ALU operands.
REQ-009 Port: alu_func  output  1  ALU function code: RADD=0, RMUL=1.
REQ-010 Port: alu_result  input  n  combinational ALU result for the current operands and function.
REQ-011 Port: busy  output  1  high while a transform is in progress.
REQ-012 Port: done  output  1  one-cycle completion pulse.
REQ-013 Port: x_out, y_out  output  n each  transformed point; held until the next completion.

Function
REQ-014 Computation: x_out = a11*x + a12*y + b1 and y_out = a21*x + a22*y + b2, using only the shared ALU.
REQ-015 RMUL product: bits [14:7] of the 16-bit signed product (truncating, floor toward -inf); RADD wraps modulo 2^n with no saturation.
REQ-016 FSM states: IDLE, M11, M12, A1, B1, M21, M22, A2, B2, DONE; one cycle per state.
REQ-017 Transitions:
- IDLE -> M11 when start=1; otherwise stay in IDLE.
- M11 -> M12 -> A1 -> B1 -> M21 -> M22 -> A2 -> B2 -> DONE -> IDLE, unconditionally.
REQ-018 Capture: on the edge leaving IDLE with start=1, x_in, y_in, a11..a22, b1 and b2 are registered; later input changes do not affect the running transform.
REQ-019 ALU drive per state:
- M11: x, a11, RMUL; result -> acc.
- M12: y, a12, RMUL; result -> tmp.
- A1: acc, tmp, RADD; result -> acc.
- B1: acc, b1, RADD; result -> x_out.
- M21, M22, A2, B2: same pattern using a21, a22, b2; B2 result -> y_out.
REQ-020 ALU drive outside M11..B2: alu_a=0, alu_b=0, alu_func=RADD.
REQ-021 busy=1 exactly in states M11..B2.
REQ-022 done=1 exactly in state DONE, the cycle after B2; latency from the start edge to done high is 9 cycles.
REQ-023 x_out and y_out are registered and change only at the B1 and B2 edges respectively.
REQ-024 start while busy or in DONE is ignored and not queued; start held high continuously yields back-to-back transforms every 10 cycles.

Reset
REQ-025 While nReset=0: state=IDLE; busy=0; done=0; x_out=y_out=0; acc=tmp=0; all captured operand registers=0.
REQ-026 Reset asserted mid-transform aborts it immediately (asynchronous); no done pulse is produced, and start is honoured on the first clk edge after release.

Structure
REQ-027 Shared package affine_pkg holds the state enum typedef and the ALU function constants RADD and RMUL, so the sequencer and the ALU use identical codes.
REQ-028 No sub-module; the ALU is external and connected through the alu_* ports, and the FSM, capture registers and accumulator are inline.

Verification
REQ-029 Basic transform: x=20, y=40, a11=a12=a21=0x40, a22=0xC0, b1=0x05, b2=0xFD -> done at cycle 9; x_out=0x23, y_out=0xF3.
REQ-030 Wrap-around: x=y=100, a11=a12=0x7F, b1=100 -> x_out=0x2A (198+100 wraps modulo 256).
REQ-031 Negative floor: x=0xFF, y=0, a11=0x40, a12=0, b1=0 -> x_out=0xFF.
REQ-032 Ignored start: start re-pulsed at cycles 3 and 9, with inputs changed at cycle 2 -> exactly one done pulse and original results; alu_* equal to 0/0/RADD in IDLE.
REQ-033 Reset mid-operation: nReset low during A2 -> all outputs 0 immediately, no done pulse; a new start after release completes correctly.
REQ-034 Continuous start: start held high for 30 cycles -> done pulses at cycles 9, 19 and 29; busy low for exactly 2 cycles between runs.

Source files
------------

// File: rtl/affine_pkg.sv
// Shared definitions for the affine sequencer and its external ALU:
// state encoding and ALU function codes.
package affine_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE, M11, M12, A1, B1, M21, M22, A2, B2, DONE
  } state_t;

  localparam logic RADD = 1'b0;
  localparam logic RMUL = 1'b1;

  // States in which a transform is running on the ALU
  function automatic logic is_busy(input state_t s);
    return (s inside {M11, M12, A1, B1, M21, M22, A2, B2});
  endfunction

endpackage

// File: rtl/affine_seq.sv
// Sequences a 2-D affine transform (A*p + b) through a single shared,
// external ALU: four Q1.7 multiplies and four wrapping adds, one per cycle.
module affine_seq
  import affine_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  input  logic [n-1:0] x_in,
  input  logic [n-1:0] y_in,
  input  logic [n-1:0] a11,
  input  logic [n-1:0] a12,
  input  logic [n-1:0] a21,
  input  logic [n-1:0] a22,
  input  logic [n-1:0] b1,
  input  logic [n-1:0] b2,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic         alu_func,
  input  logic [n-1:0] alu_result,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] x_out,
  output logic [n-1:0] y_out
);

  state_t state, state_next;

  logic [n-1:0] cap_x, cap_y, cap_a11, cap_a12, cap_a21, cap_a22, cap_b1, cap_b2;
  logic [n-1:0] acc, tmp;

  // State register, operand capture and result write-back
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      acc     <= '0;
      tmp     <= '0;
      cap_x   <= '0;
      cap_y   <= '0;
      cap_a11 <= '0;
      cap_a12 <= '0;
      cap_a21 <= '0;
      cap_a22 <= '0;
      cap_b1  <= '0;
      cap_b2  <= '0;
    end else begin
      state <= state_next;
      busy  <= is_busy(state_next);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            cap_x   <= x_in;
            cap_y   <= y_in;
            cap_a11 <= a11;
            cap_a12 <= a12;
            cap_a21 <= a21;
            cap_a22 <= a22;
            cap_b1  <= b1;
            cap_b2  <= b2;
          end
        end
        M11, A1, M21, A2: acc   <= alu_result;
        M12, M22:         tmp   <= alu_result;
        B1:               x_out <= alu_result;
        B2:               y_out <= alu_result;
        default: ;
      endcase
    end
  end

  // Next-state and ALU operand/function selection
  always_comb begin
    state_next = state;
    alu_a      = '0;
    alu_b      = '0;
    alu_func   = RADD;
    case (state)
      IDLE: if (start) state_next = M11;
      M11: begin
        state_next = M12;
        alu_a      = cap_x;
        alu_b      = cap_a11;
        alu_func   = RMUL;
      end
      M12: begin
        state_next = A1;
        alu_a      = cap_y;
        alu_b      = cap_a12;
        alu_func   = RMUL;
      end
      A1: begin
        state_next = B1;
        alu_a      = acc;
        alu_b      = tmp;
      end
      B1: begin
        state_next = M21;
        alu_a      = acc;
        alu_b      = cap_b1;
      end
      M21: begin
        state_next = M22;
        alu_a      = cap_x;
        alu_b      = cap_a21;
        alu_func   = RMUL;
      end
      M22: begin
        state_next = A2;
        alu_a      = cap_y;
        alu_b      = cap_a22;
        alu_func   = RMUL;
      end
      A2: begin
        state_next = B2;
        alu_a      = acc;
        alu_b      = tmp;
      end
      B2: begin
        state_next = DONE;
        alu_a      = acc;
        alu_b      = cap_b2;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule
